alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 16, is the operand and result width; legal values are 4 to 32.
REQ-002 Parameter SHAMT_W, default 4, equals clog2(WIDTH) and is the width of the variable shift amount.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: an operation request is present.
REQ-006 Port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 Port alu_op, input, 4 bits: operation select.
REQ-008 Port alu_input1, input, WIDTH bits: operand A.
REQ-009 Port alu_input2, input, WIDTH bits: operand B; bits [SHAMT_W-1:0] are the shift amount for SHLV/SHRV.
REQ-010 Port out_valid, output, 1 bit: the result is available.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 Port alu_result, output, WIDTH bits: the registered result.
REQ-013 Port overflow_flag, output, 1 bit: the registered overflow for the result.

Function
REQ-014 Opcodes SHALL be decoded as follows; all are two's-complement, and results wrap modulo 2^WIDTH.
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 ORR.
  - 4 NOT: ~A.
  - 5 TCP: ~A+1.
  - 6 SHL: A<<1.
  - 7 SHR: arithmetic A>>>1.
  - 8 SHLV: A<<n.
  - 9 SHRV: arithmetic A>>>n.
  - 10 MUL: low WIDTH bits of unsigned A*B.
  - 11 SLT: 1 if signed A<B, else 0.
  - 12-15 illegal: result 0, overflow 0.
REQ-015 overflow_flag SHALL be set as follows, and is 0 for every other opcode.
  - ADD/SUB: signed overflow.
  - TCP: A equals the most-negative value.
  - SHL: A[WIDTH-1] != A[WIDTH-2].
  - SHLV: any step changes the sign bit (sticky).
  - MUL: the upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-016 The controller SHALL have three states: IDLE, EXEC and DONE.
  - in_ready = (state==IDLE) and not reset.
  - out_valid = (state==DONE).
REQ-017 A request SHALL be accepted only at a rising edge with in_valid and in_ready both high (edge E0); operands and opcode are captured at E0 and inputs are ignored at all other times.
REQ-018 For opcodes 0-7, 11 and 12-15, and for SHLV/SHRV with n=0, the result SHALL be registered at E0 and the state becomes DONE at E0.
REQ-019 SHLV/SHRV with n>0 SHALL go to EXEC at E0, shift one bit per edge, and enter DONE at edge E0+n.
REQ-020 MUL SHALL go to EXEC at E0 and perform one shift-add step per edge using a 2*WIDTH accumulator, entering DONE at edge E0+WIDTH.
REQ-021 In EXEC, in_ready SHALL be 0 and alu_result/overflow_flag hold the previous completed values until DONE is entered.
REQ-022 In DONE, alu_result and overflow_flag SHALL be stable; at an edge with out_ready=1 the state returns to IDLE, and no request is accepted at that same edge.
REQ-023 While out_ready=0 in DONE, the state, result and flag SHALL be held indefinitely (backpressure).
REQ-024 alu_result and overflow_flag SHALL retain the last value after DONE→IDLE until the next completion.

Reset
REQ-025 While reset=1, and immediately on its assertion, the outputs SHALL take these values, regardless of clk and regardless of the current state:
  - state = IDLE.
  - out_valid = 0.
  - in_ready = 0.
  - alu_result = 0.
  - overflow_flag = 0.
  - iteration counter and accumulator cleared.
REQ-026 A reset asserted mid-EXEC SHALL abort the operation with no result delivered; after release, in_ready=1 in the first cycle.

Verification (WIDTH=16)
REQ-027 ADD 0x7FFF+0x0001 → alu_result=0x8000, overflow_flag=1, out_valid high in the cycle after E0.
REQ-028 MUL 0x0100*0x0100 → 0x0000 with overflow_flag=1, DONE at E0+16, in_ready=0 throughout; MUL 0x00FF*0x0003 → 0x02FD with overflow_flag=0.
REQ-029 SHRV A=0x8000, n=3 → 0xF000, DONE at E0+3, flag 0; SHLV A=0x4001, n=2 → 0x0004, flag 1; SHRV with n=0 → A unchanged, DONE at E0.
REQ-030 Backpressure: with out_ready held 0 for 5 cycles after DONE, out_valid, alu_result and overflow_flag stay constant, in_ready=0, and a concurrent in_valid pulse is not accepted.
REQ-031 Reset asserted at E0+7 of a MUL → out_valid, alu_result and overflow_flag are all 0 immediately; after release, SUB 0x8000-0x0001 → 0x7FFF with flag 1.
REQ-032 TCP 0x8000 → 0x8000 with flag 1; SLT 0xFFFF,0x0001 → 0x0001; opcode 0xF → 0x0000 with flag 0.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops complete at accept; variable shifts and
// multiply iterate one step per clock, with a valid/ready handshake on both sides.
module alu_multicycle #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_input1,
  input  logic [WIDTH-1:0]   alu_input2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_result,
  output logic               overflow_flag
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_TCP  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHLV = 4'd8;
  localparam logic [3:0] OP_SHRV = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [3:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sh_q;
  logic               sticky_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  logic               accept;
  logic               iter_start;
  logic               last_step;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   fast_res;
  logic               fast_ovf;
  logic [WIDTH-1:0]   sh_step;
  logic               sh_step_ovf;
  logic [ACC_W-1:0]   acc_step;

  // Handshake and control decode
  assign in_ready   = (state_q == IDLE) && !reset;
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign shamt      = alu_input2[SHAMT_W-1:0];
  assign iter_start = (alu_op == OP_MUL) ||
                      (((alu_op == OP_SHLV) || (alu_op == OP_SHRV)) && (shamt != '0));
  assign last_step  = (cnt_q == CNT_W'(1));

  assign sum  = alu_input1 + alu_input2;
  assign diff = alu_input1 - alu_input2;

  // Results that are fully known at the accepting edge
  always_comb begin
    fast_res = '0;
    fast_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        fast_res = sum;
        fast_ovf = (alu_input1[WIDTH-1] == alu_input2[WIDTH-1]) &&
                   (sum[WIDTH-1] != alu_input1[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res = diff;
        fast_ovf = (alu_input1[WIDTH-1] != alu_input2[WIDTH-1]) &&
                   (diff[WIDTH-1] != alu_input1[WIDTH-1]);
      end
      OP_AND: fast_res = alu_input1 & alu_input2;
      OP_ORR: fast_res = alu_input1 | alu_input2;
      OP_NOT: fast_res = ~alu_input1;
      OP_TCP: begin
        fast_res = ~alu_input1 + WIDTH'(1);
        fast_ovf = (alu_input1 == MIN_NEG);
      end
      OP_SHL: begin
        fast_res = {alu_input1[WIDTH-2:0], 1'b0};
        fast_ovf = (alu_input1[WIDTH-1] != alu_input1[WIDTH-2]);
      end
      OP_SHR:  fast_res = {alu_input1[WIDTH-1], alu_input1[WIDTH-1:1]};
      OP_SHLV: fast_res = alu_input1;
      OP_SHRV: fast_res = alu_input1;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) < $signed(alu_input2))};
      default: begin
        fast_res = '0;
        fast_ovf = 1'b0;
      end
    endcase
  end

  // One iteration step for the variable shifts and the shift-add multiplier
  always_comb begin
    sh_step     = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    sh_step_ovf = 1'b0;
    if (op_q == OP_SHLV) begin
      sh_step     = {sh_q[WIDTH-2:0], 1'b0};
      sh_step_ovf = (sh_q[WIDTH-1] != sh_q[WIDTH-2]);
    end
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = iter_start ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q          <= '0;
      cnt_q         <= '0;
      sh_q          <= '0;
      sticky_q      <= 1'b0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      alu_result    <= '0;
      overflow_flag <= 1'b0;
    end else if (accept) begin
      op_q     <= alu_op;
      sh_q     <= alu_input1;
      sticky_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= ACC_W'(alu_input1);
      mplier_q <= alu_input2;
      cnt_q    <= (alu_op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
      if (!iter_start) begin
        alu_result    <= fast_res;
        overflow_flag <= fast_ovf;
      end
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (op_q == OP_MUL) begin
        acc_q    <= acc_step;
        mcand_q  <= {mcand_q[ACC_W-2:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        if (last_step) begin
          alu_result    <= acc_step[WIDTH-1:0];
          overflow_flag <= |acc_step[ACC_W-1:WIDTH];
        end
      end else begin
        sh_q     <= sh_step;
        sticky_q <= sticky_q | sh_step_ovf;
        if (last_step) begin
          alu_result    <= sh_step;
          overflow_flag <= sticky_q | sh_step_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=16): directed corner vectors,
// random ops against a reference model, backpressure and mid-operation reset.
module tb_alu_multicycle;

  localparam int unsigned W = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_TCP  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHLV = 4'd8;
  localparam logic [3:0] OP_SHRV = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_input1;
  logic [W-1:0] alu_input2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         overflow_flag;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_checks;
  int           n_fail;
  logic [W-1:0] last_res;
  logic         last_ovf;

  alu_multicycle #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .alu_input1    (alu_input1),
    .alu_input2    (alu_input2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .overflow_flag (overflow_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model built on signed integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    int           sa;
    int           sb_v;
    int           r;
    int           n;
    logic [31:0]  p;
    sa    = int'($signed(a));
    sb_v  = int'($signed(b));
    n     = int'(b[3:0]);
    e.res = '0;
    e.ovf = 1'b0;
    e.lat = 0;
    case (op)
      OP_ADD: begin r = sa + sb_v; e.res = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      OP_SUB: begin r = sa - sb_v; e.res = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      OP_AND: e.res = a & b;
      OP_ORR: e.res = a | b;
      OP_NOT: e.res = ~a;
      OP_TCP: begin r = -sa; e.res = r[15:0]; e.ovf = (r > 32767); end
      OP_SHL: begin r = sa * 2; e.res = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      OP_SHR: begin r = sa >>> 1; e.res = r[15:0]; end
      OP_SHLV: begin
        e.res = a << n;
        for (int i = 1; i <= n; i++) begin
          if (a[15-i] != a[15]) e.ovf = 1'b1;
        end
        e.lat = n;
      end
      OP_SHRV: begin r = sa >>> n; e.res = r[15:0]; e.lat = n; end
      OP_MUL: begin
        p     = {16'h0000, a} * {16'h0000, b};
        e.res = p[15:0];
        e.ovf = |p[31:16];
        e.lat = 16;
      end
      OP_SLT: e.res = (sa < sb_v) ? 16'h0001 : 16'h0000;
      default: begin e.res = '0; e.ovf = 1'b0; end
    endcase
    return e;
  endfunction

  // Entered just after a rising edge with the DUT idle; leaves it idle again.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e, input int hold);
    exp_t got_e;
    int   k;
    check({tag, "_idle_ready"}, in_ready, 1);
    in_valid   = 1'b1;
    alu_op     = op;
    alu_input1 = a;
    alu_input2 = b;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    alu_op     = 4'($urandom);
    alu_input1 = 16'($urandom);
    alu_input2 = 16'($urandom);
    k = 0;
    while (!out_valid && k < 100) begin
      check({tag, "_exec_ready"}, in_ready, 0);
      check({tag, "_exec_res_hold"}, alu_result, last_res);
      check({tag, "_exec_ovf_hold"}, overflow_flag, last_ovf);
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, out_valid, 1);
    check({tag, "_latency"}, k, e.lat);
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 0, 1);
    end else begin
      got_e = sb.pop_front();
      check({tag, "_res"}, alu_result, got_e.res);
      check({tag, "_ovf"}, overflow_flag, got_e.ovf);
    end
    check({tag, "_done_ready"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid   = (i == 1);
      alu_op     = OP_ADD;
      alu_input1 = 16'h0001;
      alu_input2 = 16'h0001;
      @(posedge clk); #1;
      check({tag, "_bp_valid"}, out_valid, 1);
      check({tag, "_bp_res"}, alu_result, e.res);
      check({tag, "_bp_ovf"}, overflow_flag, e.ovf);
      check({tag, "_bp_ready"}, in_ready, 0);
    end
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_release_valid"}, out_valid, 0);
    check({tag, "_release_ready"}, in_ready, 1);
    check({tag, "_release_res"}, alu_result, e.res);
    last_res = e.res;
    last_ovf = e.ovf;
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic o, input int l);
    exp_t e;
    e.res = r;
    e.ovf = o;
    e.lat = l;
    return e;
  endfunction

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks   = 0;
    n_fail     = 0;
    last_res   = '0;
    last_ovf   = 1'b0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    alu_op     = '0;
    alu_input1 = '0;
    alu_input2 = '0;

    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", alu_result, 0);
    check("rst_ovf", overflow_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready_clocked", in_ready, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, mk(16'h8000, 1'b1, 0), 0);
    run_op("mul_ovf",  OP_MUL,  16'h0100, 16'h0100, mk(16'h0000, 1'b1, 16), 0);
    run_op("mul_bp",   OP_MUL,  16'h00FF, 16'h0003, mk(16'h02FD, 1'b0, 16), 5);
    run_op("shrv3",    OP_SHRV, 16'h8000, 16'h0003, mk(16'hF000, 1'b0, 3), 0);
    run_op("shlv2",    OP_SHLV, 16'h4001, 16'h0002, mk(16'h0004, 1'b1, 2), 0);
    run_op("shrv0",    OP_SHRV, 16'h1234, 16'h0010, mk(16'h1234, 1'b0, 0), 0);
    run_op("tcp_min",  OP_TCP,  16'h8000, 16'h0000, mk(16'h8000, 1'b1, 0), 0);
    run_op("slt",      OP_SLT,  16'hFFFF, 16'h0001, mk(16'h0001, 1'b0, 0), 0);
    run_op("illegal",  4'hF,    16'hABCD, 16'h1234, mk(16'h0000, 1'b0, 0), 0);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      run_op("rand", rop, ra, rb, model(rop, ra, rb), 0);
    end

    run_op("pre_abort", OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b1, 0), 0);

    // Abort a multiply seven edges in; no result may appear
    check("abort_idle_ready", in_ready, 1);
    in_valid   = 1'b1;
    alu_op     = OP_MUL;
    alu_input1 = 16'h1234;
    alu_input2 = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", alu_result, 0);
    check("abort_ovf", overflow_flag, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("abort_hold_valid", out_valid, 0);
    #2 reset = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    last_res = '0;
    last_ovf = 1'b0;
    run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, mk(16'h7FFF, 1'b1, 0), 0);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
